regs_mp_sb: RTL and testbench
=============================

// Module: regs_mp_sb
// PURPOSE
// - Parametrised multi-port register file for the multicycle CPU: NUM_RD combinational read ports, two write ports, r0 hard-wired to zero.
// - Adds a per-register pending scoreboard for long-latency writebacks: MEM loads, later MUL/DIV.
// - Sits between decode (reads, reservations) and the two writeback sources: ALU on port 0, memory/long-op on port 1.
// PARAMETERS
// - DATA_W    32  register width in bits
// - ADDR_W    5   register index width; DEPTH = 2**ADDR_W entries, entry 0 reads 0
// - NUM_RD    2   number of read ports (1..4)
// - BYPASS    1   1: same-cycle write data is forwarded to reads; 0: reads return stored value only
// - MAX_PEND  4   maximum number of simultaneously pending registers (1..DEPTH-1)
// PORTS
// - clk       in   1                  system clock, rising edge
// - rst       in   1                  asynchronous reset, active-low (0 = reset)
// - rd_addr   in   NUM_RD*ADDR_W      packed read addresses; port k at [k*ADDR_W +: ADDR_W]
// - rd_data   out  NUM_RD*DATA_W      packed read data
// - rd_pend   out  NUM_RD             read port k targets a still-pending register
// - we0       in   1                  write enable, port 0 (ALU writeback)
// - wa0       in   ADDR_W             write address, port 0
// - wd0       in   DATA_W             write data, port 0
// - we1       in   1                  write enable, port 1 (long-latency writeback)
// - wa1       in   ADDR_W             write address, port 1
// - wd1       in   DATA_W             write data, port 1
// - rsv_valid in   1                  request to mark rsv_addr pending
// - rsv_addr  in   ADDR_W             register to reserve
// - rsv_ready out  1                  pend_cnt < MAX_PEND; a reservation is accepted only when valid & ready
// - pend_cnt  out  $clog2(MAX_PEND+1) number of pending registers
// - err       out  1                  sticky protocol error flag
// BEHAVIOUR
// - Reset (rst=0, async): all entries 0, all pending bits 0, pend_cnt 0, err 0, rsv_ready 1. Reset mid-operation discards all in-flight reservations.
// - Writes: a write to address 0 is ignored. Data is stored on the rising clk edge.
//   - we0 & we1 to the same nonzero address: port 1 wins; no error is flagged.
// - Reads: combinational, zero latency. Address 0 returns 0 and rd_pend=0.
//   - BYPASS=1, write to the same address this cycle: return the write data, using port-1 priority. Otherwise return the stored value.
// - rd_pend[k]: pend[addr] & ~(BYPASS & same-cycle write to addr). BYPASS=0 ignores same-cycle writes.
// - Scoreboard, evaluated per cycle in this order:
//   1. Any write (either port) to a pending register clears its pending bit.
//   2. An accepted reservation (rsv_valid & rsv_ready & rsv_addr!=0) sets the pending bit; set wins over a same-cycle clear of the same address.
//   - rsv_addr=0 is ignored; the count is unchanged.
//   - rsv_valid & ~rsv_ready: dropped; the requester must hold and retry.
// - pend_cnt(next) = pend_cnt + (new bit set) - (bits cleared, 0..2). Width is exact and never wraps. Invariant: pend_cnt == popcount(pend).
// - Reserving an already-pending register with no same-cycle clear: err <= 1. The bit stays set and the count is unchanged.
// - A port-1 write to a non-pending nonzero register: err <= 1. The data is still written.
// - err clears only on reset.
// - rsv_ready is combinational from pend_cnt and reflects state before the current edge.
// STRUCTURE
// - Package regs_pkg: DATA_W/ADDR_W defaults, PEND_W = $clog2(MAX_PEND+1), function onehot_addr().
// - Sub-module regs_rd_port: one read port (zero check, bypass mux, pending mask), instantiated NUM_RD times via generate.
// - Top level holds the storage array, pending vector, counter and err.
// TESTING
// 1. Reset: write r5=0xA5A5A5A5 and reserve r6, then pull rst low mid-cycle -> immediately all reads 0, rd_pend 0, pend_cnt 0, err 0.
// 2. Write/bypass: we0 wa0=3 wd0=0x11 while rd_addr[0]=3 -> rd_data[0]=0x11 the same cycle (BYPASS=1). With BYPASS=0 -> old value the same cycle, 0x11 the next cycle.
// 3. Dual write conflict: we0 wa0=7 wd0=1 and we1 wa1=7 wd1=2 -> r7=2. A write of 0xFF to r0 -> r0 still reads 0.
// 4. Scoreboard: reserve r9 -> rd_pend=1, pend_cnt=1. Then we1 wa1=9 wd1=0x42 -> bypassed read 0x42, rd_pend=0 the same cycle, pend_cnt=0 the next cycle.
// 5. Full: reserve r1..r4 -> pend_cnt=4, rsv_ready=0. Reserve r5 -> dropped, pend_cnt stays 4. we1 to r2 plus reserve r5 the same cycle -> pend_cnt=4.
// 6. Errors: reserve r8 twice with no write -> err=1, pend_cnt=1. After reset, we1 wa1=10 non-pending -> err=1 and r10 is written.

Source files
------------

// File: rtl/regs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regs_pkg
//  Purpose  : Shared defaults and helpers for the multi-port register file
//             with pending-writeback scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
package regs_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int MAX_PEND_DEF = 4;
    localparam int PEND_W_DEF   = $clog2(MAX_PEND_DEF + 1);

    // Bit idx of the one-hot decode of addr. Address fields up to 8 bits wide.
    function automatic logic onehot_addr(input logic [7:0] addr, input logic [7:0] idx);
        return addr == idx;
    endfunction

endpackage : regs_pkg
`default_nettype wire

// File: rtl/regs_rd_port.sv
`default_nettype none
// ============================================================================
//  Module   : regs_rd_port
//  Purpose  : One combinational read port: r0 forced to zero, optional
//             same-cycle write forwarding (port 1 has priority), and the
//             pending flag masked by a forwarded write.
//  Revision : 1.0 - initial release
// ============================================================================
module regs_rd_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] stored,
    input  logic              pend_bit,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    output logic [DATA_W-1:0] data,
    output logic              pend
);

    logic addr_zero;
    logic hit0;
    logic hit1;
    logic fwd_en;

    assign addr_zero = (addr == '0);
    assign hit0      = we0 && (wa0 == addr);
    assign hit1      = we1 && (wa1 == addr);
    assign fwd_en    = (BYPASS != 0);

    // Read mux: zero register, then forwarded write data (port 1 first), then storage
    always_comb begin
        data = stored;
        pend = 1'b0;
        if (addr_zero) begin
            data = '0;
        end else begin
            if (fwd_en && hit1) begin
                data = wd1;
            end else if (fwd_en && hit0) begin
                data = wd0;
            end
            // A write landing this cycle retires the pending state as seen by the reader
            pend = pend_bit && !(fwd_en && (hit0 || hit1));
        end
    end

endmodule : regs_rd_port
`default_nettype wire

// File: rtl/regs_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regs_mp_sb
//  Purpose  : Multi-port register file (NUM_RD read ports, two write ports,
//             r0 hard-wired to zero) with a per-register pending scoreboard
//             for long-latency writebacks arriving on write port 1.
//  Revision : 1.0 - initial release
// ============================================================================
module regs_mp_sb
    import regs_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int MAX_PEND = MAX_PEND_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_RD*ADDR_W-1:0]          rd_addr,
    output logic [NUM_RD*DATA_W-1:0]          rd_data,
    output logic [NUM_RD-1:0]                 rd_pend,
    input  logic                              we0,
    input  logic [ADDR_W-1:0]                 wa0,
    input  logic [DATA_W-1:0]                 wd0,
    input  logic                              we1,
    input  logic [ADDR_W-1:0]                 wa1,
    input  logic [DATA_W-1:0]                 wd1,
    input  logic                              rsv_valid,
    input  logic [ADDR_W-1:0]                 rsv_addr,
    output logic                              rsv_ready,
    output logic [$clog2(MAX_PEND+1)-1:0]     pend_cnt,
    output logic                              err
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PEND_W = $clog2(MAX_PEND + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;

    logic              clr0;
    logic              clr1;
    logic              clr_same;
    logic [PEND_W-1:0] clr_n;
    logic              accept;
    logic              rsv_clr_hit;
    logic              rsv_dup;
    logic              inc;
    logic              wr1_orphan;
    logic [DEPTH-1:0]  clr_mask;
    logic [DEPTH-1:0]  set_mask;

    // Count is bounded by MAX_PEND because reservations are refused at the limit
    assign rsv_ready = (pend_cnt < PEND_W'(MAX_PEND));

    // Scoreboard decisions for this cycle: clears from writes, then the reservation
    always_comb begin
        clr0        = we0 && (wa0 != '0) && pend[wa0];
        clr1        = we1 && (wa1 != '0) && pend[wa1];
        clr_same    = clr0 && clr1 && (wa0 == wa1);
        clr_n       = PEND_W'(clr0) + PEND_W'(clr1 && !clr_same);
        accept      = rsv_valid && rsv_ready && (rsv_addr != '0);
        rsv_clr_hit = (clr0 && (wa0 == rsv_addr)) || (clr1 && (wa1 == rsv_addr));
        rsv_dup     = accept && pend[rsv_addr] && !rsv_clr_hit;
        inc         = accept && !rsv_dup;
        wr1_orphan  = we1 && (wa1 != '0) && !pend[wa1];
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_mask
            assign clr_mask[i] = (clr0 && onehot_addr(8'(wa0), 8'(i)))
                              || (clr1 && onehot_addr(8'(wa1), 8'(i)));
            assign set_mask[i] = accept && onehot_addr(8'(rsv_addr), 8'(i));
        end
    endgenerate

    // Register storage; port 1 is written last so it wins an address collision
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (we0 && (wa0 != '0)) begin
                mem[wa0] <= wd0;
            end
            if (we1 && (wa1 != '0)) begin
                mem[wa1] <= wd1;
            end
        end
    end

    // Pending vector, its population count and the sticky protocol error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend     <= '0;
            pend_cnt <= '0;
            err      <= 1'b0;
        end else begin
            pend     <= (pend & ~clr_mask) | set_mask;
            pend_cnt <= pend_cnt - clr_n + PEND_W'(inc);
            err      <= err | rsv_dup | wr1_orphan;
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] addr_k;
            assign addr_k = rd_addr[k*ADDR_W +: ADDR_W];

            regs_rd_port #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .BYPASS (BYPASS)
            ) u_rd_port (
                .addr     (addr_k),
                .stored   (mem[addr_k]),
                .pend_bit (pend[addr_k]),
                .we0      (we0),
                .wa0      (wa0),
                .wd0      (wd0),
                .we1      (we1),
                .wa1      (wa1),
                .wd1      (wd1),
                .data     (rd_data[k*DATA_W +: DATA_W]),
                .pend     (rd_pend[k])
            );
        end
    endgenerate

endmodule : regs_mp_sb
`default_nettype wire

// File: tb/tb_regs_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regs_mp_sb
//  Purpose  : Self-checking bench for regs_mp_sb. Two instances (forwarding
//             on and off) share stimulus and are compared every cycle with a
//             behavioural model of registers, pending set and error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regs_mp_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  ra0, ra1;
    logic [9:0]  rd_addr;
    logic        we0, we1, rsv_valid;
    logic [4:0]  wa0, wa1, rsv_addr;
    logic [31:0] wd0, wd1;

    logic [63:0] rd_data_a, rd_data_n;
    logic [1:0]  rd_pend_a, rd_pend_n;
    logic        rdy_a, rdy_n, err_a, err_n;
    logic [2:0]  cnt_a, cnt_n;

    int n_chk  = 0;
    int n_pass = 0;
    bit go     = 1'b0;

    assign rd_addr = {ra1, ra0};

    always #5 clk = ~clk;

    regs_mp_sb #(.BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_pend(rd_pend_a),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rdy_a),
        .pend_cnt(cnt_a), .err(err_a)
    );

    regs_mp_sb #(.BYPASS(0)) u_dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_pend(rd_pend_n),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rdy_n),
        .pend_cnt(cnt_n), .err(err_n)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_pend;
    logic        m_err;

    function automatic bit m_ready();
        return $countones(m_pend) < 4;
    endfunction

    function automatic bit m_accept();
        return rsv_valid && m_ready() && (rsv_addr != 0);
    endfunction

    function automatic bit written(input logic [4:0] a);
        return (a != 0) && ((we0 && wa0 == a) || (we1 && wa1 == a));
    endfunction

    function automatic logic [31:0] m_next_pend();
        logic [31:0] p;
        p = m_pend;
        if (we0 && wa0 != 0) p[wa0] = 1'b0;
        if (we1 && wa1 != 0) p[wa1] = 1'b0;
        if (m_accept()) p[rsv_addr] = 1'b1;
        return p;
    endfunction

    function automatic bit m_err_now();
        bit orphan, dup;
        orphan = we1 && (wa1 != 0) && !m_pend[wa1];
        dup    = m_accept() && m_pend[rsv_addr] && !written(rsv_addr);
        return orphan || dup;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && we1 && wa1 == a) return wd1;
        if (byp && we0 && wa0 == a) return wd0;
        return m_regs[a];
    endfunction

    function automatic bit exp_pend(input logic [4:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && written(a)) return 1'b0;
        return m_pend[a];
    endfunction

    // Model state advance on each clock edge; async reset mirrors the design
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
            m_pend <= 32'h0;
            m_err  <= 1'b0;
        end else begin
            if (we0 && wa0 != 0) m_regs[wa0] <= wd0;
            if (we1 && wa1 != 0) m_regs[wa1] <= wd1;
            m_pend <= m_next_pend();
            m_err  <= m_err | m_err_now();
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic cmp_inst(input string tag, input bit byp, input logic [63:0] d,
                            input logic [1:0] p, input logic rdy, input logic [2:0] c,
                            input logic e);
        chk({tag, "_rd0"},  d[31:0],  exp_rd(ra0, byp));
        chk({tag, "_rd1"},  d[63:32], exp_rd(ra1, byp));
        chk({tag, "_pnd0"}, p[0],     exp_pend(ra0, byp));
        chk({tag, "_pnd1"}, p[1],     exp_pend(ra1, byp));
        chk({tag, "_rdy"},  rdy,      m_ready());
        chk({tag, "_cnt"},  c,        $countones(m_pend));
        chk({tag, "_err"},  e,        m_err);
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (go) begin
            cmp_inst("byp", 1'b1, rd_data_a, rd_pend_a, rdy_a, cnt_a, err_a);
            cmp_inst("nob", 1'b0, rd_data_n, rd_pend_n, rdy_n, cnt_n, err_n);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; wa0 = 0; wd0 = 0;
        we1 = 0; wa1 = 0; wd1 = 0;
        rsv_valid = 0; rsv_addr = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    function automatic logic [4:0] pick_pending();
        logic [4:0] x;
        x = 5'($urandom_range(1, 15));
        for (int t = 0; t < 16; t++) begin
            if (m_pend[x]) return x;
            x = 5'($urandom_range(1, 15));
        end
        return x;
    endfunction

    function automatic logic [4:0] pick_free();
        logic [4:0] x;
        x = 5'($urandom_range(0, 15));
        for (int t = 0; t < 6; t++) begin
            if (!m_pend[x]) return x;
            x = 5'($urandom_range(0, 15));
        end
        return x;
    endfunction

    initial begin
        idle();
        ra0 = 0; ra1 = 0;
        #1 rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        go  = 1'b1;

        // Reset state
        mid();
        chk("reset_cnt", cnt_a, 3'd0);
        chk("reset_rdy", rdy_a, 1'b1);
        chk("reset_err", err_a, 1'b0);

        // Asynchronous reset in mid-cycle
        tick();
        we0 = 1; wa0 = 5; wd0 = 32'hA5A5A5A5;
        rsv_valid = 1; rsv_addr = 6;
        tick();
        idle();
        ra0 = 5; ra1 = 6;
        mid();
        chk("pre_rst_r5", rd_data_a[31:0], 64'hA5A5A5A5);
        chk("pre_rst_pend6", rd_pend_a[1], 1'b1);
        rst = 1'b0;
        #1;
        chk("async_rst_data", rd_data_a, 64'h0);
        chk("async_rst_pend", rd_pend_a, 2'b00);
        chk("async_rst_cnt", cnt_a, 3'd0);
        chk("async_rst_rdy", rdy_a, 1'b1);
        tick();
        rst = 1'b1;

        // Forwarding vs stored-only read
        tick();
        we0 = 1; wa0 = 3; wd0 = 32'h11; ra0 = 3;
        mid();
        chk("bypass_same_cycle", rd_data_a[31:0], 64'h11);
        chk("nobypass_same_cycle", rd_data_n[31:0], 64'h0);
        tick();
        idle();
        mid();
        chk("nobypass_next_cycle", rd_data_n[31:0], 64'h11);

        // Dual-write collision on a reserved register, and r0 write
        tick();
        rsv_valid = 1; rsv_addr = 7;
        tick();
        idle();
        we0 = 1; wa0 = 7; wd0 = 32'h1;
        we1 = 1; wa1 = 7; wd1 = 32'h2;
        tick();
        idle();
        ra0 = 7;
        mid();
        chk("dual_write_r7", rd_data_a[31:0], 64'h2);
        chk("dual_write_err", err_a, 1'b0);
        tick();
        we0 = 1; wa0 = 0; wd0 = 32'hFF; ra0 = 0;
        tick();
        idle();
        mid();
        chk("r0_reads_zero", rd_data_a[31:0], 64'h0);

        // Scoreboard reserve and long-latency writeback
        tick();
        rsv_valid = 1; rsv_addr = 9;
        tick();
        idle();
        ra0 = 9;
        mid();
        chk("sb_pend9", rd_pend_a[0], 1'b1);
        chk("sb_cnt1", cnt_a, 3'd1);
        tick();
        we1 = 1; wa1 = 9; wd1 = 32'h42;
        mid();
        chk("sb_wb_data", rd_data_a[31:0], 64'h42);
        chk("sb_wb_pend", rd_pend_a[0], 1'b0);
        tick();
        idle();
        mid();
        chk("sb_cnt0", cnt_a, 3'd0);

        // Full scoreboard
        for (int a = 1; a <= 4; a++) begin
            tick();
            rsv_valid = 1; rsv_addr = 5'(a);
        end
        tick();
        rsv_valid = 1; rsv_addr = 5;
        mid();
        chk("full_cnt4", cnt_a, 3'd4);
        chk("full_not_ready", rdy_a, 1'b0);
        tick();
        we1 = 1; wa1 = 2; wd1 = 32'h22;
        mid();
        chk("full_drop_cnt4", cnt_a, 3'd4);
        tick();
        we1 = 0;
        mid();
        chk("full_after_wb_cnt3", cnt_a, 3'd3);
        chk("full_after_wb_ready", rdy_a, 1'b1);
        tick();
        idle();
        mid();
        chk("full_retry_cnt4", cnt_a, 3'd4);
        chk("full_no_err", err_a, 1'b0);

        // Protocol errors
        tick();
        do_reset();
        rsv_valid = 1; rsv_addr = 8;
        tick();
        rsv_valid = 1; rsv_addr = 8;
        tick();
        idle();
        mid();
        chk("dup_rsv_err", err_a, 1'b1);
        chk("dup_rsv_cnt", cnt_a, 3'd1);
        tick();
        do_reset();
        we1 = 1; wa1 = 10; wd1 = 32'h77;
        tick();
        idle();
        ra0 = 10;
        mid();
        chk("orphan_wr_err", err_a, 1'b1);
        chk("orphan_wr_data", rd_data_a[31:0], 64'h77);

        // Randomized traffic
        tick();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            rst = (c % 300 == 299) ? 1'b0 : 1'b1;
            we0 = 1'($urandom_range(0, 1));
            wa0 = 5'($urandom_range(0, 15));
            wd0 = $urandom;
            we1 = ($urandom_range(0, 2) == 0);
            wa1 = ($urandom_range(0, 39) == 0) ? 5'($urandom_range(0, 15)) : pick_pending();
            wd1 = $urandom;
            rsv_valid = ($urandom_range(0, 2) == 0);
            rsv_addr  = ($urandom_range(0, 29) == 0) ? 5'($urandom_range(0, 15)) : pick_free();
            case ($urandom_range(0, 3))
                0: ra1 = wa0;
                1: ra1 = wa1;
                default: ra1 = 5'($urandom_range(0, 15));
            endcase
            ra0 = ($urandom_range(0, 1) == 0) ? wa1 : 5'($urandom_range(0, 15));
            tick();
        end
        idle();
        rst = 1'b1;
        mid();
        go = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_regs_mp_sb
`default_nettype wire
